muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that takes HI/LO arithmetic out of the single-cycle EX stage.
- EX issues Mult/Multu/Div/Divu operands with a start strobe. The block holds the pipeline with busy while it iterates, then writes HI/LO through the existing whi/wlo/wHiData/wLoData interface.
- It sits beside EX and feeds the HI/LO register file.
- An exception/interrupt flush cancels an operation in flight without writing HI/LO.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- MUL_LAT, 3, number of cycles spent in MUL state; must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EX requests a HI/LO arithmetic op; sampled only in IDLE
- op  in  2  00 Mult, 01 Multu, 10 Div, 11 Divu
- opa  in  DATA_W  rs value (multiplicand / dividend)
- opb  in  DATA_W  rt value (multiplier / divisor)
- flush  in  1  exception/eret flush from exception logic; cancels operation
- busy  out  1  stall request to IF/ID/EX
- done  out  1  one-cycle completion pulse
- whi  out  1  HI write enable
- wlo  out  1  LO write enable
- wHiData  out  DATA_W  HI write data
- wLoData  out  DATA_W  LO write data
- div_by_zero  out  1  one-cycle flag, valid with done

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; busy, done, whi, wlo, div_by_zero=0; wHiData, wLoData=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0: latch op, opa, opb.
  - Signed ops: store operand magnitudes and result-sign bits.
  - Mult/Multu -> MUL with counter=MUL_LAT-1.
  - Div/Divu with opb!=0 -> DIV with counter=31.
  - Div/Divu with opb==0 -> DONE.
  - start with flush=1: ignored.
- MUL: product = |opa|*|opb| as a 64-bit unsigned value, registered once. Counter decrements each cycle; at 0 -> DONE.
- DIV: restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder. Counter decrements; at 0 -> DONE.
- DONE, exactly one cycle: done=1, whi=1, wlo=1; next state is IDLE.
  - Mult: {HI,LO} = product, negated in 64 bits if the operand signs differ.
  - Multu: {HI,LO} = product unsigned.
  - Div: LO = quotient, negated if the signs differ. HI = remainder, negated if the dividend is negative. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero: HI=opa, LO=0xFFFFFFFF, div_by_zero=1.
- busy:
  - Combinational: (IDLE and start and !flush) or state in {MUL, DIV}.
  - Low in DONE, so the pipeline advances in the same cycle HI/LO are written.
- whi, wlo, done, div_by_zero: registered. Low in every cycle except DONE. wHiData/wLoData hold their last value otherwise.
- Latency, counted from the start cycle (cycle 0) to the done cycle:
  - Mult/Multu: MUL_LAT+1.
  - Div/Divu: 33.
  - Divide by zero: 1.
- start while not IDLE: ignored; no re-latch.
- flush in MUL or DIV: next edge -> IDLE. No done/whi/wlo; busy falls the following cycle.
- flush in DONE: the write still completes, because the instruction has already retired its stall.
- A new start is accepted in the cycle after DONE, back-to-back.
- Operands must not be assumed stable after the start cycle; only the latched copies are used.

Test Plan:
- Mult, opa=0xFFFFFFFB (-5), opb=3, MUL_LAT=3 -> busy cycles 0–3; done/whi/wlo at cycle 4; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Multu, opa=0xFFFFFFFF, opb=2 -> HI=0x00000001, LO=0xFFFFFFFE. Mult with opa=0x80000000, opb=0x80000000 -> HI=0x40000000, LO=0.
- Div, opa=0xFFFFFFF9 (-7), opb=2 -> done at cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divu, opa=100, opb=7 -> LO=14, HI=2. Divu with opb=0, opa=0x1234 -> done at cycle 1, div_by_zero=1, HI=0x1234, LO=0xFFFFFFFF.
- Div started; flush at cycle 10 -> IDLE at cycle 11 with busy=0; no whi/wlo ever. A start at cycle 5 (mid-op) has no effect on the result.
- rst asserted mid-DIV at cycle 20 -> all outputs 0 immediately without waiting for a clock edge. Multu issued back-to-back in the cycle after DONE -> accepted, correct result.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer beside EX: stalls the pipeline while
// iterating, then writes HI/LO for one cycle through the whi/wlo/wHiData/wLoData port.
module muldiv_ctrl #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              whi,
  output logic              wlo,
  output logic [DATA_W-1:0] wHiData,
  output logic [DATA_W-1:0] wLoData,
  output logic              div_by_zero
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mag_a_q, mag_a_d;
  logic [DATA_W-1:0]   mag_b_q, mag_b_d;
  logic                quo_neg_q, quo_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   opa_mag, opb_mag;
  logic [DATA_W:0]     trial;
  logic                ge;
  logic [DATA_W-1:0]   rem_next, quo_next;
  logic [2*DATA_W-1:0] product, product_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    busy      = 1'b0;

    // op[0]==0 selects the signed variants; work on magnitudes and fix signs at the end
    a_neg   = ~op[0] & opa[DATA_W-1];
    b_neg   = ~op[0] & opb[DATA_W-1];
    opa_mag = a_neg ? -opa : opa;
    opb_mag = b_neg ? -opb : opb;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    trial    = {rem_q, quo_q[DATA_W-1]};
    ge       = (trial >= {1'b0, mag_b_q});
    rem_next = ge ? DATA_W'(trial - {1'b0, mag_b_q}) : trial[DATA_W-1:0];
    quo_next = {quo_q[DATA_W-2:0], ge};

    product   = {{DATA_W{1'b0}}, mag_a_q} * {{DATA_W{1'b0}}, mag_b_q};
    product_s = quo_neg_q ? -product : product;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy      = 1'b1;
          mag_a_d   = opa_mag;
          mag_b_d   = opb_mag;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          if (!op[1]) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (opb == '0) begin
            state_d = DONE;
            hi_d    = opa;
            lo_d    = '1;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d   = CNT_W'(DATA_W - 1);
            rem_d   = '0;
            quo_d   = opa_mag;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d      = DONE;
          {hi_d, lo_d} = product_s;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV: begin
        busy = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          if (cnt_q == '0) begin
            state_d = DONE;
            lo_d    = quo_neg_q ? -quo_next : quo_next;
            hi_d    = rem_neg_q ? -rem_next : rem_next;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done        = done_q;
  assign whi         = done_q;
  assign wlo         = done_q;
  assign div_by_zero = dbz_q;
  assign wHiData     = hi_q;
  assign wLoData     = lo_q;

endmodule
